// File: rtl/dump_tx_pkg.sv
// Shared types and frame helpers for the register-dump transmitter.
// DUMP_TX_CKSUM_EN adds a fourth, XOR-checksum byte to every frame.
package dump_tx_pkg;

  localparam logic [3:0]  SYNC_NIBBLE = 4'h5;
  localparam int unsigned DUMP_W      = 20;

`ifdef DUMP_TX_CKSUM_EN
  localparam int unsigned FRAME_BYTES = 4;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BYTE0 = 3'd1,
    BYTE1 = 3'd2,
    BYTE2 = 3'd3,
    BYTE3 = 3'd4
  } tx_state_t;
  localparam tx_state_t LAST_BYTE = BYTE3;
`else
  localparam int unsigned FRAME_BYTES = 3;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    BYTE2 = 2'd3
  } tx_state_t;
  localparam tx_state_t LAST_BYTE = BYTE2;
`endif

  typedef struct packed {
    logic [15:0] reg_data;
    logic [3:0]  reg_idx;
  } dump_word_t;

  function automatic logic [7:0] frame_cksum(input dump_word_t w);
    return {SYNC_NIBBLE, w.reg_idx} ^ w.reg_data[15:8] ^ w.reg_data[7:0];
  endfunction

  // Byte presented on the link while in state st; IDLE shows zero.
  function automatic logic [7:0] frame_byte(input tx_state_t st, input dump_word_t w);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      IDLE:    b = 8'h00;
      BYTE0:   b = {SYNC_NIBBLE, w.reg_idx};
      BYTE1:   b = w.reg_data[15:8];
      BYTE2:   b = w.reg_data[7:0];
`ifdef DUMP_TX_CKSUM_EN
      BYTE3:   b = frame_cksum(w);
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/reg_dump_tx_if.sv
// Dump-word input and byte-link output of the register-dump transmitter.
interface reg_dump_tx_if;
  import dump_tx_pkg::*;

  logic       dump_valid;
  dump_word_t dump_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    input  dump_valid,
    input  dump_data,
    input  tx_ready,
    output tx_valid,
    output tx_data
  );

  modport slave (
    output dump_valid,
    output dump_data,
    output tx_ready,
    input  tx_valid,
    input  tx_data
  );

endinterface

// File: rtl/reg_dump_tx_fifo.sv
// Synchronous FIFO for dump words; a push while full is accepted only when a
// pop happens on the same edge. DEPTH must be a power of two so pointers wrap.
module dump_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == {CNT_W{1'b0}});
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update.
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d   = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/reg_dump_tx.sv
// Register-dump transmitter: queues core dump words and sends each as a
// 3-byte frame (4 bytes with DUMP_TX_CKSUM_EN) on a valid/ready byte link.
module reg_dump_tx
  import dump_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  reg_dump_tx_if.master                 link,
  input  logic                          clear_overflow,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_t  state_q, state_d;
  dump_word_t frame_q, frame_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       overflow_q, overflow_d;
  logic       pop_s;
  logic       drop_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  dump_word_t head_s;

  dump_fifo #(
    .WIDTH (DUMP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (link.dump_valid),
    .pop     (pop_s),
    .wr_data (link.dump_data),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count)
  );

  // Frame sequencing; the last accepted byte pops the next word with no bubble.
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = BYTE0;
        end else begin
          state_d = IDLE;
        end
      end
      BYTE0:   state_d = link.tx_ready ? BYTE1 : BYTE0;
      BYTE1:   state_d = link.tx_ready ? BYTE2 : BYTE1;
`ifdef DUMP_TX_CKSUM_EN
      BYTE2:   state_d = link.tx_ready ? BYTE3 : BYTE2;
`endif
      LAST_BYTE: begin
        if (link.tx_ready && !fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = BYTE0;
        end else if (link.tx_ready) begin
          state_d = IDLE;
        end else begin
          state_d = LAST_BYTE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame capture, registered link outputs and sticky overflow.
  always_comb begin
    frame_d    = pop_s ? head_s : frame_q;
    tx_valid_d = (state_d != IDLE);
    tx_data_d  = frame_byte(state_d, frame_d);
    drop_s     = link.dump_valid && fifo_full_s && !pop_s;
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Transmitter state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      frame_q    <= '{reg_data: 16'h0000, reg_idx: 4'h0};
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign link.tx_valid = tx_valid_q;
  assign link.tx_data  = tx_data_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q != IDLE) || (fifo_count != {CNT_W{1'b0}});

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: cycle vectors for single frames and stalls,
// plus hand sequences for back-to-back frames, overflow and mid-frame reset.
module tb_reg_dump_tx;

`ifdef DUMP_TX_CKSUM_EN
  localparam int FB = 4;
`else
  localparam int FB = 3;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       overflow;
  logic [2:0] fifo_count;
  logic       busy;

  reg_dump_tx_if link();

  reg_dump_tx #(.FIFO_DEPTH(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .link           (link),
    .clear_overflow (clear_overflow),
    .overflow       (overflow),
    .fifo_count     (fifo_count),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        dv;
    logic [19:0] dd;
    logic        rdy;
    logic        clr;
    logic        etv;
    logic [7:0]  etd;
    logic        eovf;
    logic [2:0]  ecnt;
    logic        ebusy;
  } vec_t;

  vec_t vecs[$];

  logic [19:0] cw [4];
  logic [19:0] dw [8];
  int          peak;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic dv, input logic [19:0] dd, input logic rdy, input logic clr);
    link.dump_valid = dv;
    link.dump_data  = dd;
    link.tx_ready   = rdy;
    clear_overflow  = clr;
  endtask

  task automatic add(input logic dv, input logic [19:0] dd, input logic rdy, input logic clr,
                     input logic etv, input logic [7:0] etd, input logic eovf,
                     input logic [2:0] ecnt, input logic ebusy);
    vec_t v;
    v.dv = dv; v.dd = dd; v.rdy = rdy; v.clr = clr;
    v.etv = etv; v.etd = etd; v.eovf = eovf; v.ecnt = ecnt; v.ebusy = ebusy;
    vecs.push_back(v);
  endtask

  // Expected frame byte k of word w: {5,idx}, data hi, data lo, xor of those.
  function automatic logic [7:0] exp_byte(input logic [19:0] w, input int k);
    logic [7:0] b0, b1, b2;
    b0 = {4'h5, w[3:0]};
    b1 = w[19:12];
    b2 = w[11:4];
    case (k)
      0:       return b0;
      1:       return b1;
      2:       return b2;
      default: return b0 ^ b1 ^ b2;
    endcase
  endfunction

  task automatic expect_frame(input string name, input logic [19:0] w);
    for (int k = 0; k < FB; k++) begin
      check({name, ".tx_valid"}, {31'd0, link.tx_valid}, 32'd1);
      check({name, ".tx_data"}, {24'd0, link.tx_data}, {24'd0, exp_byte(w, k)});
      step();
    end
  endtask

  initial begin
    drive(1'b0, 20'h00000, 1'b0, 1'b0);

    // Single frame {BEEF, 3} with tx_ready held high.
    add(1'b1, 20'hBEEF3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b1);
    add(1'b0, 20'h00000, 1'b1, 1'b0, 1'b1, 8'h53, 1'b0, 3'd0, 1'b1);
    add(1'b0, 20'h00000, 1'b1, 1'b0, 1'b1, 8'hBE, 1'b0, 3'd0, 1'b1);
    add(1'b0, 20'h00000, 1'b1, 1'b0, 1'b1, 8'hEF, 1'b0, 3'd0, 1'b1);
`ifdef DUMP_TX_CKSUM_EN
    add(1'b0, 20'h00000, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 3'd0, 1'b1);
`endif
    add(1'b0, 20'h00000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    // Frame {1234, A} stalled for five cycles on its second byte.
    add(1'b1, 20'h1234A, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b1);
    add(1'b0, 20'h00000, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 3'd0, 1'b1);
    add(1'b0, 20'h00000, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      add(1'b0, 20'h00000, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 3'd0, 1'b1);
    end
    add(1'b0, 20'h00000, 1'b1, 1'b0, 1'b1, 8'h34, 1'b0, 3'd0, 1'b1);
`ifdef DUMP_TX_CKSUM_EN
    add(1'b0, 20'h00000, 1'b1, 1'b0, 1'b1, 8'h7C, 1'b0, 3'd0, 1'b1);
`endif
    add(1'b0, 20'h00000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

    cw = '{20'h11111, 20'h22222, 20'h33333, 20'h44440};
    dw = '{20'h0A0A1, 20'h1B1B2, 20'h2C2C3, 20'h3D3D4,
           20'h4E4E5, 20'hDEAD6, 20'hFACE7, 20'h55AA8};

    // Asynchronous reset values, checked between clock edges.
    #12;
    check("reset.tx_valid", {31'd0, link.tx_valid}, 32'd0);
    check("reset.tx_data", {24'd0, link.tx_data}, 32'h00);
    check("reset.overflow", {31'd0, overflow}, 32'd0);
    check("reset.fifo_count", {29'd0, fifo_count}, 32'd0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].dv, vecs[i].dd, vecs[i].rdy, vecs[i].clr);
      step();
      check($sformatf("vec%0d.tx_valid", i), {31'd0, link.tx_valid}, {31'd0, vecs[i].etv});
      if (vecs[i].etv) begin
        check($sformatf("vec%0d.tx_data", i), {24'd0, link.tx_data}, {24'd0, vecs[i].etd});
      end
      check($sformatf("vec%0d.overflow", i), {31'd0, overflow}, {31'd0, vecs[i].eovf});
      check($sformatf("vec%0d.fifo_count", i), {29'd0, fifo_count}, {29'd0, vecs[i].ecnt});
      check($sformatf("vec%0d.busy", i), {31'd0, busy}, {31'd0, vecs[i].ebusy});
    end

    // Four dumps on consecutive cycles: frames follow with no idle byte slot.
    peak = 0;
    for (int c = 0; c <= 4 * FB + 1; c++) begin
      if (c < 4) drive(1'b1, cw[c], 1'b1, 1'b0);
      else       drive(1'b0, 20'h00000, 1'b1, 1'b0);
      step();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (c == 0) begin
        check("b2b.first_count", {29'd0, fifo_count}, 32'd1);
        check("b2b.first_valid", {31'd0, link.tx_valid}, 32'd0);
      end else if (c <= 4 * FB) begin
        check($sformatf("b2b.valid%0d", c), {31'd0, link.tx_valid}, 32'd1);
        check($sformatf("b2b.data%0d", c), {24'd0, link.tx_data},
              {24'd0, exp_byte(cw[(c - 1) / FB], (c - 1) % FB)});
      end else begin
        check("b2b.end_valid", {31'd0, link.tx_valid}, 32'd0);
        check("b2b.end_busy", {31'd0, busy}, 32'd0);
      end
    end
    check("b2b.peak_count", peak, 32'd3);
    check("b2b.overflow", {31'd0, overflow}, 32'd0);

    // Six dumps into a stalled link: one framed, four queued, the sixth dropped.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, dw[i], 1'b0, 1'b0);
      step();
      if (i == 4) begin
        check("ovf.before_drop", {31'd0, overflow}, 32'd0);
        check("ovf.full_count", {29'd0, fifo_count}, 32'd4);
      end
    end
    check("ovf.set", {31'd0, overflow}, 32'd1);
    check("ovf.count_after_drop", {29'd0, fifo_count}, 32'd4);
    check("ovf.stall_data", {24'd0, link.tx_data}, {24'd0, exp_byte(dw[0], 0)});
    drive(1'b0, 20'h00000, 1'b0, 1'b0);
    step();
    check("ovf.sticky", {31'd0, overflow}, 32'd1);
    drive(1'b0, 20'h00000, 1'b0, 1'b1);
    step();
    check("ovf.cleared", {31'd0, overflow}, 32'd0);
    drive(1'b1, dw[6], 1'b0, 1'b1);
    step();
    check("ovf.clear_vs_drop", {31'd0, overflow}, 32'd1);
    check("ovf.count_clear_drop", {29'd0, fifo_count}, 32'd4);
    drive(1'b0, 20'h00000, 1'b0, 1'b0);
    step();
    check("ovf.sticky2", {31'd0, overflow}, 32'd1);
    // Drain the frame; a push on the edge that pops from a full FIFO is kept.
    for (int k = 0; k < FB; k++) begin
      check("ovf.d0_data", {24'd0, link.tx_data}, {24'd0, exp_byte(dw[0], k)});
      if (k == FB - 1) drive(1'b1, dw[7], 1'b1, 1'b0);
      else             drive(1'b0, 20'h00000, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 20'h00000, 1'b1, 1'b0);
    check("ovf.push_pop_count", {29'd0, fifo_count}, 32'd4);
    check("ovf.push_pop_ovf", {31'd0, overflow}, 32'd1);
    expect_frame("ovf.f1", dw[1]);
    expect_frame("ovf.f2", dw[2]);
    expect_frame("ovf.f3", dw[3]);
    expect_frame("ovf.f4", dw[4]);
    expect_frame("ovf.f7", dw[7]);
    check("ovf.drained_valid", {31'd0, link.tx_valid}, 32'd0);
    check("ovf.drained_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a frame with two words queued.
    drive(1'b1, cw[0], 1'b1, 1'b0);
    step();
    drive(1'b1, cw[1], 1'b1, 1'b0);
    step();
    drive(1'b1, cw[2], 1'b1, 1'b0);
    step();
    check("rst.pre_data", {24'd0, link.tx_data}, {24'd0, exp_byte(cw[0], 1)});
    check("rst.pre_count", {29'd0, fifo_count}, 32'd2);
    drive(1'b0, 20'h00000, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst.tx_valid", {31'd0, link.tx_valid}, 32'd0);
    check("rst.fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.overflow", {31'd0, overflow}, 32'd0);
    step();
    step();
    #2;
    reset_n = 1'b1;
    drive(1'b0, 20'h00000, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("rst.quiet_valid%0d", c), {31'd0, link.tx_valid}, 32'd0);
      check($sformatf("rst.quiet_count%0d", c), {29'd0, fifo_count}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
